switch_debounce_hex_display: RTL and testbench

- Generalised switch-to-display block for the board's slide switches, LEDs and active-low 7-segment digits.
- Handles CHANNELS switches. Each channel has:
  - a 2-flop synchroniser;
  - a debouncer;
  - a 4-bit rising-edge counter;
  - one LED and one 7-segment digit.
- Each digit shows either the debounced switch state (0/1) or the channel's toggle count in hex (0-F), selected by MODE.
- Sits between the board pins and any logic that consumes clean switch levels.

---
 rtl/switch_debounce_hex_display.sv | 76 +++++++
 tb/tb_switch_debounce_hex_display.sv | 139 +++++++++++++
 2 files changed

// File: rtl/switch_debounce_hex_display.sv
// switch_debounce_hex_display: synchronised, debounced switches with edge counters and hex digits (option DEBOUNCE_ACTIVITY_EN)
module switch_debounce_hex_display #(
  parameter int CHANNELS = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   SW,
  input  logic                  MODE,
  input  logic                  CLR,
  output logic [CHANNELS-1:0]   LEDR,
  output logic [8*CHANNELS-1:0] HEX,
  output logic [CHANNELS-1:0]   STABLE
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [CHANNELS-1:0] s1, s2, stable;
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction
  // two-flop synchroniser for the raw switch levels
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic st, acc, dp;
    logic [3:0] ec;
    logic [7:0] hx;
    assign acc = (s2[i] != st) && (cnt == LAST);
`ifdef DEBOUNCE_ACTIVITY_EN
    assign dp = ~|cnt;
`else
    assign dp = 1'b1;
`endif
    // debounce, rising-edge count and registered digit for one channel
    always_ff @(posedge clock)
      if (reset) begin
        cnt <= '0;
        st  <= 1'b0;
        ec  <= 4'd0;
        hx  <= 8'hC0;
      end else begin
        cnt <= (s2[i] == st || acc) ? '0 : cnt + W'(1);
        st  <= acc ? s2[i] : st;
        ec  <= CLR ? 4'd0 : (acc && s2[i]) ? ec + 4'd1 : ec;
        hx  <= {dp, seg(MODE ? ec : {3'b0, st})};
      end
    assign stable[i] = st;
    assign HEX[8*i +: 8] = hx;
  end
  assign LEDR = stable;
  assign STABLE = stable;
endmodule

// File: tb/tb_switch_debounce_hex_display.sv
// tb_switch_debounce_hex_display: directed and random checks against a run-length reference model
module tb_switch_debounce_hex_display;
  localparam int N = 6;
  localparam int D = 4;
  logic clock = 0, reset = 1, MODE = 0, CLR = 0;
  logic [N-1:0] SW = '0;
  logic [N-1:0] LEDR, STABLE;
  logic [8*N-1:0] HEX;
  int checks = 0, errors = 0;
  logic [7:0] segt [16];
  logic [N-1:0] m1, m2, mst;
  int run [N];
  logic [3:0] mc [N];
  logic [8*N-1:0] mhex;
  switch_debounce_hex_display #(.CHANNELS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .SW(SW), .MODE(MODE), .CLR(CLR),
    .LEDR(LEDR), .HEX(HEX), .STABLE(STABLE)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model();
    logic [3:0] v;
    logic dp;
    if (reset) begin
      m1 = '0; m2 = '0; mst = '0; mhex = {N{8'hC0}};
      for (int i = 0; i < N; i++) begin run[i] = 0; mc[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        v = MODE ? mc[i] : {3'b0, mst[i]};
        dp = 1'b1;
`ifdef DEBOUNCE_ACTIVITY_EN
        dp = (run[i] == 0);
`endif
        mhex[8*i +: 8] = {dp, segt[v][6:0]};
      end
      for (int i = 0; i < N; i++) begin
        if (m2[i] != mst[i]) begin
          run[i]++;
          if (run[i] == D) begin
            mst[i] = m2[i];
            run[i] = 0;
            if (mst[i]) mc[i] = mc[i] + 4'd1;
          end
        end else run[i] = 0;
        if (CLR) mc[i] = 0;
      end
      m2 = m1;
      m1 = SW;
    end
  endtask
  task automatic tick();
    @(posedge clock);
    model();
    @(negedge clock);
    check("ledr", 64'(LEDR), 64'(mst));
    check("stable", 64'(STABLE), 64'(mst));
    check("hex", 64'(HEX), 64'(mhex));
  endtask
  task automatic wait_led(input int ch, output int n);
    n = 0;
    while (n < 20 && !LEDR[ch]) begin
      tick();
      n++;
    end
  endtask
  int n;
  int hold [N];
  initial begin
    segt[0] = 8'hC0; segt[1] = 8'hF9; segt[2] = 8'hA4; segt[3] = 8'hB0;
    segt[4] = 8'h99; segt[5] = 8'h92; segt[6] = 8'h82; segt[7] = 8'hF8;
    segt[8] = 8'h80; segt[9] = 8'h90; segt[10] = 8'h88; segt[11] = 8'h83;
    segt[12] = 8'hC6; segt[13] = 8'hA1; segt[14] = 8'h86; segt[15] = 8'h8E;
    @(negedge clock);
    tick(); tick();
    reset = 0;
    tick();
    check("reset_ledr", 64'(LEDR), 64'd0);
    check("reset_hex", 64'(HEX), 64'({N{8'hC0}}));
    SW[2] = 1;
    wait_led(2, n);
    check("ch2_latency", 64'(n), 64'd6);
    check("ch2_others", 64'(LEDR), 64'h04);
    tick();
    check("ch2_hex", 64'(HEX[23:16]), 64'hF9);
    SW[0] = 1;
    repeat (3) tick();
    SW[0] = 0;
    repeat (10) begin
      tick();
      check("pulse_ledr0", 64'(LEDR[0]), 64'd0);
    end
    MODE = 1;
    repeat (17) begin
      SW[1] = 1;
      repeat (8) tick();
      SW[1] = 0;
      repeat (8) tick();
    end
    check("wrap_hex1", 64'(HEX[15:8]), 64'hF9);
    SW[3] = 1;
    repeat (5) tick();
    CLR = 1;
    tick();
    CLR = 0;
    check("clr_ledr3", 64'(LEDR[3]), 64'd1);
    tick();
    check("clr_hex3", 64'(HEX[31:24]), 64'hC0);
    SW[4] = 1;
    repeat (3) tick();
    reset = 1;
    tick();
    check("rst_ledr4", 64'(LEDR[4]), 64'd0);
    check("rst_hex", 64'(HEX), 64'({N{8'hC0}}));
    reset = 0;
    wait_led(4, n);
    check("rst_latency4", 64'(n), 64'd6);
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          SW[i] = 1'($urandom);
          hold[i] = $urandom_range(1, 9);
        end else hold[i]--;
      end
      if ($urandom_range(0, 15) == 0) MODE = ~MODE;
      CLR = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
